// File: rtl/ctrl_del_fsm.sv
// rtl/ctrl_del_fsm.sv - DEL sub-controller: key lookup then entry invalidate
module ctrl_del_fsm #(
  parameter int KEY_WIDTH   = 64,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES),
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic [1:0]           status_o,
  output logic [1:0]           err_code_o,
  output logic                 lookup_req_o,
  output logic [KEY_WIDTH-1:0] lookup_key_o,
  input  logic                 lookup_ack_i,
  input  logic                 lookup_hit_i,
  input  logic [IDX_WIDTH-1:0] lookup_idx_i,
  output logic                 del_req_o,
  output logic [IDX_WIDTH-1:0] del_idx_o,
  input  logic                 del_ack_i
);

  typedef enum logic [2:0] {
    DEL_ST_START,
    DEL_ST_CHECK_EXISTS,
    ST_DEL_DELETE,
    ST_DEL_DONE,
    ST_DEL_ERROR
  } del_substate_e;

  // status_o packs {done, error}
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  localparam logic [1:0] ERR_MISS    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  // Counter wide enough to hold TIMEOUT; a disabled timeout still needs one bit
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TLAST);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  del_substate_e          state_q;
  logic [CW-1:0]          cnt_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [1:0]             err_q;
  logic                   timeout_hit;
  sub_cmd_t               status;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Sequencer: lookup, invalidate on hit, one-cycle done/error report
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DEL_ST_START;
      cnt_q   <= '0;
      key_q   <= '0;
      idx_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      case (state_q)
        DEL_ST_START: begin
          if (start_i) begin
            key_q   <= key_i;
            cnt_q   <= '0;
            state_q <= DEL_ST_CHECK_EXISTS;
          end
        end
        DEL_ST_CHECK_EXISTS: begin
          if (abort_i) begin
            err_q   <= ERR_ABORT;
            state_q <= ST_DEL_ERROR;
          end else if (lookup_ack_i && lookup_hit_i) begin
            idx_q   <= lookup_idx_i;
            cnt_q   <= '0;
            state_q <= ST_DEL_DELETE;
          end else if (lookup_ack_i) begin
            err_q   <= ERR_MISS;
            state_q <= ST_DEL_ERROR;
          end else if (timeout_hit) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= ST_DEL_ERROR;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DEL_DELETE: begin
          // The entry is already gone once acked, so the ack wins over abort
          if (del_ack_i) begin
            state_q <= ST_DEL_DONE;
          end else if (abort_i) begin
            err_q   <= ERR_ABORT;
            state_q <= ST_DEL_ERROR;
          end else if (timeout_hit) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= ST_DEL_ERROR;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DEL_DONE: begin
          state_q <= DEL_ST_START;
        end
        ST_DEL_ERROR: begin
          err_q   <= 2'b00;
          state_q <= DEL_ST_START;
        end
        default: begin
          state_q <= DEL_ST_START;
        end
      endcase
    end
  end

  // Moore decode of the registered state
  always_comb begin
    status       = '0;
    status.done  = (state_q == ST_DEL_DONE);
    status.error = (state_q == ST_DEL_ERROR);
  end

  assign busy_o       = (state_q != DEL_ST_START);
  assign status_o     = status;
  assign err_code_o   = err_q;
  assign lookup_req_o = (state_q == DEL_ST_CHECK_EXISTS);
  assign lookup_key_o = key_q;
  assign del_req_o    = (state_q == ST_DEL_DELETE);
  assign del_idx_o    = idx_q;

endmodule

// File: doc/ctrl_del_fsm.md
Name: ctrl_del_fsm

Overview:
- Sub-controller for the DEL operation of the cache controller.
- Launched by the top-level FSM while it is in ST_DEL.
- Sequences the key store: looks up the key; on a hit, issues an invalidate of the matching entry.
- Reports completion to the top FSM as a sub_cmd_t {done, error} pulse plus an error code.

Parameters:
- KEY_WIDTH, 64: width of the key compared by the key store.
- NUM_ENTRIES, 16: number of key-store entries.
- IDX_WIDTH, $clog2(NUM_ENTRIES): entry index width.
- TIMEOUT, 16: maximum cycles spent waiting for an ack in a wait state; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  launch a delete; sampled only in DEL_ST_START.
- key_i  in  KEY_WIDTH  key to delete; valid with start_i.
- abort_i  in  1  cancel the operation in progress.
- busy_o  out  1  high in every state except DEL_ST_START.
- status_o  out  sub_cmd_t  {done, error}; each bit is a one-cycle pulse.
- err_code_o  out  2  00 none, 01 key miss, 10 timeout, 11 abort; valid while status_o.error=1, else 00.
- lookup_req_o  out  1  key-store lookup request.
- lookup_key_o  out  KEY_WIDTH  latched key.
- lookup_ack_i  in  1  lookup result valid.
- lookup_hit_i  in  1  key present; qualified by lookup_ack_i.
- lookup_idx_i  in  IDX_WIDTH  matching entry; qualified by lookup_ack_i & lookup_hit_i.
- del_req_o  out  1  invalidate request.
- del_idx_o  out  IDX_WIDTH  latched entry index.
- del_ack_i  in  1  invalidate performed.

Behaviour:
- One clock (clk_i); reset rst_ni is asynchronous, active-low.
- Reset state:
  - state = DEL_ST_START; timeout counter = 0; latched key and index = 0.
  - All outputs 0: busy_o, status_o, err_code_o, lookup_req_o, lookup_key_o, del_req_o, del_idx_o.
- States use the del_substate_e encoding: DEL_ST_START, DEL_ST_CHECK_EXISTS, ST_DEL_DELETE, ST_DEL_DONE, ST_DEL_ERROR.
- Moore outputs, decoded from registered state only; no combinational input-to-output path.
  - lookup_req_o = (state == CHECK_EXISTS).
  - del_req_o = (state == DELETE).
  - status_o.done = (state == DONE).
  - status_o.error = (state == ERROR).
- DEL_ST_START:
  - start_i=1: latch key_i, clear counter, go to CHECK_EXISTS.
  - abort_i is ignored here.
- DEL_ST_CHECK_EXISTS (lookup_req_o held high, lookup_key_o stable):
  - Priority 1, abort_i: go to ERROR, code 11.
  - Priority 2, lookup_ack_i & lookup_hit_i: latch lookup_idx_i, clear counter, go to DELETE.
  - Priority 3, lookup_ack_i & !lookup_hit_i: go to ERROR, code 01.
  - Priority 4, TIMEOUT != 0 & counter == TIMEOUT-1: go to ERROR, code 10.
  - Otherwise counter += 1.
- ST_DEL_DELETE (del_req_o held high, del_idx_o stable):
  - Priority 1, del_ack_i: go to DONE. The ack beats a simultaneous abort, because the entry is already invalidated.
  - Priority 2, abort_i: go to ERROR, code 11.
  - Priority 3, timeout as above: go to ERROR, code 10.
  - Otherwise counter += 1.
- ST_DEL_DONE: one cycle, then DEL_ST_START.
- ST_DEL_ERROR: one cycle, then DEL_ST_START. err_code_o is registered on entry and cleared on exit.
- Timeout: with TIMEOUT=N>0, a request stays high for exactly N cycles without an ack, then ERROR. An ack in the final cycle beats the timeout.
- Minimum latency: start_i at cycle 0 → lookup_req_o at cycle 1.
  - Same-cycle hit ack → del_req_o at cycle 2.
  - Same-cycle del_ack_i → status_o.done at cycle 3.
  - busy_o falls at cycle 4.
- Back-to-back operations: start_i asserted while busy_o=1 is ignored and not queued. A new start is accepted in the first cycle back in DEL_ST_START.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit; the counter saturates, never wraps.
- Reset asserted mid-operation:
  - Asynchronous return to the reset state; all requests drop immediately.
  - No done/error pulse is produced.
- Acks arriving in a state that is not waiting for them (stray lookup_ack_i / del_ack_i) are ignored.

Test Plan:
- Hit path: start_i with key=0xDEAD_BEEF; lookup ack+hit with idx=5 in cycle 1; del_ack_i in cycle 2 → del_idx_o=5, lookup_key_o=0xDEADBEEF, status_o.done=1 only in cycle 3, busy_o=0 from cycle 4.
- Miss: lookup ack in the 3rd request cycle with hit=0 → del_req_o never asserted; one-cycle error pulse with err_code_o=01.
- Timeout, TIMEOUT=4, no ack → lookup_req_o high exactly 4 cycles, then error pulse with code 10. Repeat with the ack in the 4th cycle → no error, enters DELETE.
- Abort: in CHECK_EXISTS → error code 11, lookup_req_o drops the next cycle. abort_i and del_ack_i in the same cycle in DELETE → done, not error. abort_i in START → no effect.
- start_i held high continuously: exactly one operation per START visit; the second starts the cycle after DONE, with the key sampled at that cycle.
- rst_ni pulled low for one cycle mid-DELETE → del_req_o=0 asynchronously, no status pulse, state START; the next start_i operates normally.
